// File: rtl/lcd_pkg.sv
// lcd_pkg: shared RGB565 field positions, output mode codes and colour constants
package lcd_pkg;
  localparam int R_LSB = 11;
  localparam int R_MSB = 15;
  localparam int G_LSB = 5;
  localparam int G_MSB = 10;
  localparam int B_LSB = 0;
  localparam int B_MSB = 4;
  localparam logic [1:0] MODE_RAM    = 2'd0;
  localparam logic [1:0] MODE_SOLID  = 2'd1;
  localparam logic [1:0] MODE_BARS   = 2'd2;
  localparam logic [1:0] MODE_BORDER = 2'd3;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
endpackage

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: h/v raster counters with stage-0 sync, active-area and pixel x/y decode
// ports: clk_i/rst_i clock and sync reset; hs/vs raw sync (1 = in pulse); act active area;
//        frame0 high at h=v=0; x/y pixel coordinates inside the active area
module lcd_timing_gen #(
  parameter int H_SYNC = 41,
  parameter int H_BP = 2,
  parameter int H_ACTIVE = 480,
  parameter int H_FP = 2,
  parameter int V_SYNC = 10,
  parameter int V_BP = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP = 2,
  parameter int XW = $clog2(H_ACTIVE + 1),
  parameter int YW = $clog2(V_ACTIVE + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          hs,
  output logic          vs,
  output logic          act,
  output logic          frame0,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_S = HW'(H_SYNC);
  localparam logic [HW-1:0] H_A0 = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_A1 = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_S = VW'(V_SYNC);
  localparam logic [VW-1:0] V_A0 = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_A1 = VW'(V_SYNC + V_BP + V_ACTIVE);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + HW'(1);
      if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + VW'(1);
    end
  end
  assign hs = h_cnt < H_S;
  assign vs = v_cnt < V_S;
  assign act = h_cnt >= H_A0 && h_cnt < H_A1 && v_cnt >= V_A0 && v_cnt < V_A1;
  assign frame0 = h_cnt == '0 && v_cnt == '0;
  assign x = XW'(h_cnt - H_A0);
  assign y = YW'(v_cnt - V_A0);
endmodule

// File: rtl/lcd_frame_scanner.sv
// lcd_frame_scanner: RGB565 LCD scan engine fetching pixels from a fixed-latency frame RAM
// ports: clk_i/rst_i clock and sync reset; mode_i/solid_i output mode and solid colour;
//        ram_rd_* frame RAM read port; frame_start_o first-pixel pulse; LCD_* panel pins
module lcd_frame_scanner
  import lcd_pkg::*;
#(
  parameter int H_SYNC = 41,
  parameter int H_BP = 2,
  parameter int H_ACTIVE = 480,
  parameter int H_FP = 2,
  parameter int V_SYNC = 10,
  parameter int V_BP = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP = 2,
  parameter int ADDR_W = 17,
  parameter int RAM_LAT = 1,
  parameter int SYNC_POL = 0,
  parameter int RB_SWAP = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        mode_i,
  input  logic [15:0]       solid_i,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [15:0]       ram_rd_data_i,
  output logic              frame_start_o,
  output logic              LCD_hsync_o,
  output logic              LCD_vsync_o,
  output logic              LCD_de_o,
  output logic [4:0]        LCD_R_o,
  output logic [5:0]        LCD_G_o,
  output logic [4:0]        LCD_B_o
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int D = RAM_LAT + 1;
  localparam logic IDLE = SYNC_POL == 0;
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          act;
    logic          first;
    logic [1:0]    mode;
    logic [15:0]   solid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } stage_t;
  logic hs, vs, act, frame0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0] mode_q;
  logic [15:0] solid_q, raw, norm, pix;
  logic [2:0] bar;
  logic on_border;
  stage_t s0, dl;
  stage_t [D-1:0] pipe;
  lcd_timing_gen #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .XW(XW), .YW(YW)
  ) u_timing (
    .clk_i(clk_i), .rst_i(rst_i), .hs(hs), .vs(vs), .act(act),
    .frame0(frame0), .x(x), .y(y)
  );
  // mode/solid are captured at the frame origin and then ride the pipeline with their pixels
  assign s0 = '{hs: hs, vs: vs, act: act, first: act && x == '0 && y == '0,
                mode: frame0 ? mode_i : mode_q, solid: frame0 ? solid_i : solid_q,
                x: x, y: y};
  assign dl = pipe[D-1];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe <= '0;
      mode_q <= '0;
      solid_q <= '0;
      ram_rd_en_o <= 1'b0;
      ram_rd_addr_o <= '0;
    end else begin
      pipe <= {pipe[D-2:0], s0};
      mode_q <= s0.mode;
      solid_q <= s0.solid;
      ram_rd_en_o <= act;
      ram_rd_addr_o <= frame0 ? '0 : !ram_rd_en_o ? ram_rd_addr_o :
                       ram_rd_addr_o == A_LAST ? '0 : ram_rd_addr_o + ADDR_W'(1);
    end
  end
  // RAM and solid data follow the panel's R/B wiring; bars and border are true colours
  always_comb begin
    raw = dl.mode == MODE_SOLID ? dl.solid : ram_rd_data_i;
    norm = RB_SWAP != 0 ? {raw[4:0], raw[10:5], raw[15:11]} : raw;
    bar = 3'((32'(dl.x) * 8) / H_ACTIVE);
    on_border = dl.x == '0 || dl.x == XW'(H_ACTIVE - 1) || dl.y == '0 || dl.y == YW'(V_ACTIVE - 1);
    pix = !dl.act ? '0 : dl.mode == MODE_BARS ? BARS[bar] :
          (dl.mode == MODE_BORDER && on_border) ? WHITE : norm;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      LCD_hsync_o <= IDLE;
      LCD_vsync_o <= IDLE;
      LCD_de_o <= 1'b0;
      frame_start_o <= 1'b0;
      LCD_R_o <= '0;
      LCD_G_o <= '0;
      LCD_B_o <= '0;
    end else begin
      LCD_hsync_o <= dl.hs ^ IDLE;
      LCD_vsync_o <= dl.vs ^ IDLE;
      LCD_de_o <= dl.act;
      frame_start_o <= dl.first;
      LCD_R_o <= pix[R_MSB:R_LSB];
      LCD_G_o <= pix[G_MSB:G_LSB];
      LCD_B_o <= pix[B_MSB:B_LSB];
    end
  end
endmodule

// File: tb/tb_lcd_frame_scanner.sv
// tb_lcd_frame_scanner: randomized bench comparing two scanner instances (RAM latency 1 and 3) with a raster model
module tb_lcd_frame_scanner;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0] mode_i = '0;
  logic [15:0] solid_i = '0;
  logic en1, fs1, hs1, vs1, de1, en3, fs3, hs3, vs3, de3;
  logic [AW-1:0] addr1, addr3;
  logic [4:0] r1, b1, r3, b3;
  logic [5:0] g1, g3;
  logic [15:0] d1;
  logic [15:0] rp3 [3];
  logic [24:0] pins1, pins3, exp1, exp3;
  logic [1:0] hist_mode [8192];
  logic [15:0] hist_solid [8192];
  localparam logic [15:0] BAR_C [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  int tests = 0;
  int fails = 0;
  int n = 0;
  always #5 clk = ~clk;
  lcd_frame_scanner #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
    .ADDR_W(AW), .RAM_LAT(1), .SYNC_POL(0), .RB_SWAP(1)
  ) u1 (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .solid_i(solid_i),
    .ram_rd_en_o(en1), .ram_rd_addr_o(addr1), .ram_rd_data_i(d1), .frame_start_o(fs1),
    .LCD_hsync_o(hs1), .LCD_vsync_o(vs1), .LCD_de_o(de1),
    .LCD_R_o(r1), .LCD_G_o(g1), .LCD_B_o(b1)
  );
  lcd_frame_scanner #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
    .ADDR_W(AW), .RAM_LAT(3), .SYNC_POL(0), .RB_SWAP(1)
  ) u3 (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .solid_i(solid_i),
    .ram_rd_en_o(en3), .ram_rd_addr_o(addr3), .ram_rd_data_i(rp3[2]), .frame_start_o(fs3),
    .LCD_hsync_o(hs3), .LCD_vsync_o(vs3), .LCD_de_o(de3),
    .LCD_R_o(r3), .LCD_G_o(g3), .LCD_B_o(b3)
  );
  always @(posedge clk) begin
    d1 <= {12'b0, addr1};
    rp3[0] <= {12'b0, addr3};
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign pins1 = {hs1, vs1, de1, r1, g1, b1, fs1, en1, addr1};
  assign pins3 = {hs3, vs3, de3, r3, g3, b3, fs3, en3, addr3};
  // n counts clocks since reset release; raster position of the pins is n-(lat+2), of the read port n-1
  function automatic logic [24:0] model(int cyc, int lat);
    int p, h, v, x, y, fsi, p1, h1, v1, cnt;
    logic hs, vs, act, fs, en;
    logic [1:0] m;
    logic [15:0] d, c;
    logic [4:0] r, b;
    logic [5:0] g;
    logic [3:0] a;
    p = cyc - lat - 2;
    hs = 0; vs = 0; act = 0; fs = 0; r = 0; g = 0; b = 0;
    if (p >= 0) begin
      h = p % 10; v = (p / 10) % 6;
      hs = h < 2; vs = v < 1;
      act = h >= 4 && h < 8 && v >= 2 && v < 5;
      x = h - 4; y = v - 2;
      fsi = p - p % 60;
      m = hist_mode[fsi];
      fs = act && x == 0 && y == 0;
      if (act) begin
        d = m == 2'd1 ? hist_solid[fsi] : 16'(y * 4 + x);
        if (m == 2'd2 || (m == 2'd3 && (x == 0 || x == 3 || y == 0 || y == 2))) begin
          c = m == 2'd2 ? BAR_C[x * 8 / 4] : 16'hFFFF;
          r = c[15:11]; g = c[10:5]; b = c[4:0];
        end else begin
          r = d[4:0]; g = d[10:5]; b = d[15:11];
        end
      end
    end
    p1 = cyc - 1;
    en = 0; a = 0;
    if (p1 >= 0) begin
      h1 = p1 % 10; v1 = (p1 / 10) % 6;
      en = h1 >= 4 && h1 < 8 && v1 >= 2 && v1 < 5;
      cnt = v1 < 2 ? 0 : v1 >= 5 ? 12 : (v1 - 2) * 4 + (h1 < 4 ? 0 : h1 >= 8 ? 4 : h1 - 4);
      a = 4'(cnt % 12);
    end
    return {!hs, !vs, act, r, g, b, fs, en, a};
  endfunction
  task automatic tick(input logic [1:0] m, input logic [15:0] s, input logic r);
    mode_i = m;
    solid_i = s;
    rst_i = r;
    hist_mode[n] = m;
    hist_solid[n] = s;
    @(posedge clk);
    #1;
    n = r ? 0 : n + 1;
    exp1 = model(n, 1);
    exp3 = model(n, 3);
  endtask
  task automatic test_reset;
    tick(2'd0, 16'h0, 1'b1);
    tick(2'd0, 16'h0, 1'b1);
    tests++;
    if (pins1 !== 25'h1800000) begin
      fails++;
      $display("FAIL reset_lat1 got %h exp %h", pins1, 25'h1800000);
    end
    tests++;
    if (pins3 !== 25'h1800000) begin
      fails++;
      $display("FAIL reset_lat3 got %h exp %h", pins3, 25'h1800000);
    end
  endtask
  task automatic test_ram_mode;
    int pulses = 0;
    tick(2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 120; i++) begin
      tick(2'd0, 16'($urandom), 1'b0);
      pulses += fs1 ? 1 : 0;
      tests += 2;
      if (pins1 !== exp1) begin
        fails++;
        $display("FAIL ram_lat1 n=%0d got %h exp %h", n, pins1, exp1);
      end
      if (pins3 !== exp3) begin
        fails++;
        $display("FAIL ram_lat3 n=%0d got %h exp %h", n, pins3, exp3);
      end
    end
    tests++;
    if (pulses !== 2) begin
      fails++;
      $display("FAIL ram_frame_starts got %0d exp %0d", pulses, 2);
    end
  endtask
  task automatic test_solid;
    int hits = 0;
    tick(2'd1, 16'hF800, 1'b1);
    for (int i = 0; i < 120; i++) begin
      tick(2'd1, 16'hF800, 1'b0);
      hits += (de1 && r1 == 5'h00 && g1 == 6'h00 && b1 == 5'h1F) ? 1 : 0;
      tests += 2;
      if (pins1 !== exp1) begin
        fails++;
        $display("FAIL solid_lat1 n=%0d got %h exp %h", n, pins1, exp1);
      end
      if (pins3 !== exp3) begin
        fails++;
        $display("FAIL solid_lat3 n=%0d got %h exp %h", n, pins3, exp3);
      end
    end
    tests++;
    if (hits !== 24) begin
      fails++;
      $display("FAIL solid_pixels got %0d exp %0d", hits, 24);
    end
  endtask
  task automatic test_pattern(input logic [1:0] m);
    tick(m, 16'h0, 1'b1);
    for (int i = 0; i < 120; i++) begin
      tick(m, 16'($urandom), 1'b0);
      tests += 2;
      if (pins1 !== exp1) begin
        fails++;
        $display("FAIL mode%0d_lat1 n=%0d got %h exp %h", m, n, pins1, exp1);
      end
      if (pins3 !== exp3) begin
        fails++;
        $display("FAIL mode%0d_lat3 n=%0d got %h exp %h", m, n, pins3, exp3);
      end
    end
  endtask
  task automatic test_mode_switch;
    logic [15:0] s;
    s = 16'($urandom);
    tick(2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 150; i++) begin
      tick(i < 30 ? 2'd0 : 2'd1, s, 1'b0);
      tests += 2;
      if (pins1 !== exp1) begin
        fails++;
        $display("FAIL switch_lat1 n=%0d got %h exp %h", n, pins1, exp1);
      end
      if (pins3 !== exp3) begin
        fails++;
        $display("FAIL switch_lat3 n=%0d got %h exp %h", n, pins3, exp3);
      end
    end
  endtask
  task automatic test_reset_midline;
    int vs1_at = -1;
    int vs3_at = -1;
    tick(2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 37 + int'($urandom_range(0, 5)); i++) tick(2'($urandom), 16'($urandom), 1'b0);
    tick(2'd0, 16'h0, 1'b1);
    tests += 2;
    if (pins1 !== 25'h1800000) begin
      fails++;
      $display("FAIL midreset_lat1 got %h exp %h", pins1, 25'h1800000);
    end
    if (pins3 !== 25'h1800000) begin
      fails++;
      $display("FAIL midreset_lat3 got %h exp %h", pins3, 25'h1800000);
    end
    for (int i = 0; i < 20; i++) begin
      tick(2'd0, 16'h0, 1'b0);
      if (!vs1 && vs1_at < 0) vs1_at = n;
      if (!vs3 && vs3_at < 0) vs3_at = n;
    end
    tests += 2;
    if (vs1_at !== 3) begin
      fails++;
      $display("FAIL midreset_vsync_lat1 got %0d exp %0d", vs1_at, 3);
    end
    if (vs3_at !== 5) begin
      fails++;
      $display("FAIL midreset_vsync_lat3 got %0d exp %0d", vs3_at, 5);
    end
  endtask
  task automatic test_random;
    tick(2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      tick(2'($urandom), 16'($urandom), $urandom_range(0, 99) == 0);
      tests += 2;
      if (pins1 !== exp1) begin
        fails++;
        $display("FAIL random_lat1 n=%0d got %h exp %h", n, pins1, exp1);
      end
      if (pins3 !== exp3) begin
        fails++;
        $display("FAIL random_lat3 n=%0d got %h exp %h", n, pins3, exp3);
      end
    end
  endtask
  initial begin
    test_reset;
    test_ram_mode;
    test_solid;
    test_pattern(2'd2);
    test_pattern(2'd3);
    test_mode_switch;
    test_reset_midline;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout after 1ms");
    $fatal(1, "timeout");
  end
endmodule
